// File: rtl/prco_fetch.sv
// prco_fetch: instruction fetch unit driving the decoder fetch/issue handshake.
// Ports:
//   i_clk, i_reset (async, active-low)      clock and reset
//   i_en, i_fetch, i_halt                   enable, decoder fetch request, halt
//   i_jmp_en, i_jmp_addr                    PC redirect strobe and target
//   q_mem_addr, q_mem_re, i_mem_data        instruction memory read port
//   q_instr, q_ce, q_pc                     issued word, issue strobe, its address
//   q_busy                                  memory read outstanding
module prco_fetch #(
  parameter int PC_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int MEM_LAT = 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_en,
  input  logic            i_fetch,
  input  logic            i_halt,
  input  logic            i_jmp_en,
  input  logic [PC_W-1:0] i_jmp_addr,
  output logic [PC_W-1:0] q_mem_addr,
  output logic            q_mem_re,
  input  logic [15:0]     i_mem_data,
  output logic [15:0]     q_instr,
  output logic            q_ce,
  output logic [PC_W-1:0] q_pc,
  output logic            q_busy
);
  localparam logic [2:0] S_BOOT  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;
  localparam logic [1:0] LAT_LD  = 2'(MEM_LAT - 1);
  logic [2:0]      st_q, st_d;
  logic [PC_W-1:0] pc_q, pc_d, qpc_q, qpc_d;
  logic [15:0]     instr_q, instr_d;
  logic [1:0]      cnt_q, cnt_d;
  always_comb begin
    st_d    = st_q;
    pc_d    = pc_q;
    qpc_d   = qpc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    case (st_q)
      S_BOOT:  st_d = i_en ? S_REQ : S_BOOT;
      S_REQ: begin
        st_d  = S_WAIT;
        cnt_d = LAT_LD;
      end
      S_WAIT:
        if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
        else begin
          instr_d = i_mem_data;
          qpc_d   = pc_q;
          pc_d    = pc_q + PC_W'(1);
          st_d    = S_ISSUE;
        end
      S_ISSUE: st_d = S_HOLD;
      S_HOLD:  st_d = i_fetch ? (i_en ? S_REQ : S_BOOT) : S_HOLD;
      S_HALT:  st_d = S_HALT;
      default: st_d = S_BOOT;
    endcase
    // A redirect while a read is in flight (REQ or WAIT) throws the word away
    // and re-requests from the new target; elsewhere it only moves the pc.
    if (i_jmp_en && st_q != S_HALT) begin
      pc_d = i_jmp_addr;
      if (st_q == S_REQ || st_q == S_WAIT) begin
        st_d    = S_REQ;
        instr_d = instr_q;
        qpc_d   = qpc_q;
      end
    end
    if (i_halt) st_d = S_HALT;
  end
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      st_q    <= S_BOOT;
      pc_q    <= RESET_PC;
      qpc_q   <= '0;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      st_q    <= st_d;
      pc_q    <= pc_d;
      qpc_q   <= qpc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  // Strobes decode straight from state so the async reset clears them at once.
  assign q_mem_re   = st_q == S_REQ;
  assign q_mem_addr = q_mem_re ? pc_q : '0;
  assign q_ce       = st_q == S_ISSUE;
  assign q_busy     = st_q == S_REQ || st_q == S_WAIT;
  assign q_instr    = instr_q;
  assign q_pc       = qpc_q;
endmodule

// File: tb/tb_prco_fetch.sv
// tb_prco_fetch: randomized self-checking bench for two prco_fetch configurations.
module tb_prco_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en[2], fetch[2], halt[2], jmp[2];
  logic [15:0] jaddr[2], maddr[2], mdata[2], instr[2], pc[2];
  logic        re[2], ce[2], busy[2];
  logic [15:0] mem [65536];
  logic [15:0] exp_pc[2];
  logic [2:0]  pv[2] = '{3'b000, 3'b000};
  logic [15:0] pa[2][3];
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  prco_fetch #(.PC_W(16), .RESET_PC(16'h0000), .MEM_LAT(1)) u0 (
    .i_clk(clk), .i_reset(rst_n), .i_en(en[0]), .i_fetch(fetch[0]), .i_halt(halt[0]),
    .i_jmp_en(jmp[0]), .i_jmp_addr(jaddr[0]), .q_mem_addr(maddr[0]), .q_mem_re(re[0]),
    .i_mem_data(mdata[0]), .q_instr(instr[0]), .q_ce(ce[0]), .q_pc(pc[0]), .q_busy(busy[0]));

  prco_fetch #(.PC_W(16), .RESET_PC(16'hFFFF), .MEM_LAT(3)) u1 (
    .i_clk(clk), .i_reset(rst_n), .i_en(en[1]), .i_fetch(fetch[1]), .i_halt(halt[1]),
    .i_jmp_en(jmp[1]), .i_jmp_addr(jaddr[1]), .q_mem_addr(maddr[1]), .q_mem_re(re[1]),
    .i_mem_data(mdata[1]), .q_instr(instr[1]), .q_ce(ce[1]), .q_pc(pc[1]), .q_busy(busy[1]));

  // Instruction memories: data is valid only exactly MEM_LAT cycles after the read.
  always @(posedge clk)
    for (int d = 0; d < 2; d++) begin
      pv[d]    <= {pv[d][1:0], re[d]};
      pa[d][0] <= maddr[d];
      pa[d][1] <= pa[d][0];
      pa[d][2] <= pa[d][1];
    end
  assign mdata[0] = pv[0][0] ? mem[pa[0][0]] : 16'hDEAD;
  assign mdata[1] = pv[1][2] ? mem[pa[1][2]] : 16'hDEAD;

  function automatic int lat(input int d);
    return d == 0 ? 1 : 3;
  endfunction

  function automatic logic [15:0] rpc(input int d);
    return d == 0 ? 16'h0000 : 16'hFFFF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset(input string nm);
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({ce[d], re[d], busy[d], maddr[d], instr[d], pc[d]} !== 51'd0) begin
        fails++;
        $display("FAIL %s reset_outputs d%0d: ce=%b re=%b busy=%b addr=%h instr=%h pc=%h, want all zero",
                 nm, d, ce[d], re[d], busy[d], maddr[d], instr[d], pc[d]);
      end
      fetch[d] = 1'b0; halt[d] = 1'b0; jmp[d] = 1'b0; en[d] = 1'b1;
    end
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      for (int d = 0; d < 2; d++)
        if (k < 2 + lat(d)) begin
          checks++;
          if (ce[d] !== 1'b0) begin
            fails++;
            $display("FAIL %s early_ce d%0d cycle %0d: ce=%b want 0", nm, d, k, ce[d]);
          end
        end else if (k == 2 + lat(d)) begin
          checks++;
          if (ce[d] !== 1'b1 || pc[d] !== rpc(d) || instr[d] !== mem[rpc(d)]) begin
            fails++;
            $display("FAIL %s first_issue d%0d: ce=%b pc=%h instr=%h, want ce=1 pc=%h instr=%h",
                     nm, d, ce[d], pc[d], instr[d], rpc(d), mem[rpc(d)]);
          end
        end
    end
    for (int d = 0; d < 2; d++) exp_pc[d] = rpc(d) + 16'd1;
    tick();
  endtask

  // Entered just after the edge that moves the unit into REQ; follows the read
  // through to issue and one HOLD cycle.
  task automatic test_issue(input int d, input string nm);
    logic [15:0] w;
    w = mem[exp_pc[d]];
    checks++;
    if (re[d] !== 1'b1 || maddr[d] !== exp_pc[d] || busy[d] !== 1'b1 || ce[d] !== 1'b0) begin
      fails++;
      $display("FAIL %s req d%0d: re=%b addr=%h busy=%b ce=%b, want re=1 addr=%h busy=1 ce=0",
               nm, d, re[d], maddr[d], busy[d], ce[d], exp_pc[d]);
    end
    for (int i = 0; i < lat(d); i++) begin
      tick();
      checks++;
      if (re[d] !== 1'b0 || busy[d] !== 1'b1 || ce[d] !== 1'b0) begin
        fails++;
        $display("FAIL %s wait d%0d cycle %0d: re=%b busy=%b ce=%b, want re=0 busy=1 ce=0",
                 nm, d, i, re[d], busy[d], ce[d]);
      end
    end
    tick();
    checks++;
    if (ce[d] !== 1'b1 || re[d] !== 1'b0 || busy[d] !== 1'b0 || pc[d] !== exp_pc[d] || instr[d] !== w) begin
      fails++;
      $display("FAIL %s issue d%0d: ce=%b re=%b busy=%b pc=%h instr=%h, want ce=1 re=0 busy=0 pc=%h instr=%h",
               nm, d, ce[d], re[d], busy[d], pc[d], instr[d], exp_pc[d], w);
    end
    exp_pc[d] = exp_pc[d] + 16'd1;
    tick();
    checks++;
    if (ce[d] !== 1'b0 || re[d] !== 1'b0 || instr[d] !== w) begin
      fails++;
      $display("FAIL %s hold d%0d: ce=%b re=%b instr=%h, want ce=0 re=0 instr=%h", nm, d, ce[d], re[d], instr[d], w);
    end
  endtask

  task automatic test_fetch(input int d, input string nm);
    fetch[d] = 1'b1;
    tick();
    fetch[d] = 1'b0;
    test_issue(d, nm);
  endtask

  task automatic test_basic();
    tick();
    test_fetch(0, "seq_word1");
    repeat (2) tick();
    test_fetch(0, "seq_word2");
    test_fetch(1, "lat3_wrap");
    test_fetch(1, "lat3_next");
  endtask

  task automatic test_jump_wait(input int d, input int pos, input logic [15:0] t, input string nm);
    fetch[d] = 1'b1;
    tick();
    fetch[d] = 1'b0;
    tick();
    repeat (pos) tick();
    jaddr[d] = t;
    jmp[d] = 1'b1;
    tick();
    jmp[d] = 1'b0;
    exp_pc[d] = t;
    test_issue(d, nm);
    test_fetch(d, nm);
  endtask

  task automatic test_jump_hold(input int d, input logic [15:0] t, input logic wf, input string nm);
    jaddr[d] = t;
    jmp[d] = 1'b1;
    fetch[d] = wf;
    tick();
    jmp[d] = 1'b0;
    fetch[d] = 1'b0;
    if (!wf) begin
      checks++;
      if (re[d] !== 1'b0) begin
        fails++;
        $display("FAIL %s jump_no_req d%0d: re=%b want 0", nm, d, re[d]);
      end
      tick();
      fetch[d] = 1'b1;
      tick();
      fetch[d] = 1'b0;
    end
    exp_pc[d] = t;
    test_issue(d, nm);
  endtask

  task automatic test_random();
    int d;
    logic [15:0] t;
    for (int n = 0; n < 24; n++) begin
      d = $urandom_range(0, 1);
      t = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      case ($urandom_range(0, 3))
        0: begin
          repeat ($urandom_range(0, 4)) tick();
          test_fetch(d, "rnd_fetch");
        end
        1: test_jump_wait(d, $urandom_range(0, lat(d) - 1), t, "rnd_jwait");
        2: test_jump_hold(d, t, 1'b0, "rnd_jhold");
        default: test_jump_hold(d, t, 1'b1, "rnd_jfetch");
      endcase
    end
  endtask

  task automatic test_en_drop(input int d);
    int bad;
    fetch[d] = 1'b1;
    tick();
    fetch[d] = 1'b0;
    en[d] = 1'b0;
    test_issue(d, "en_drop_issue");
    fetch[d] = 1'b1;
    tick();
    fetch[d] = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (re[d] !== 1'b0 || busy[d] !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL en_low_req d%0d: %0d cycles with re/busy high, want 0", d, bad);
    end
    en[d] = 1'b1;
    tick();
    test_issue(d, "en_restart");
    fetch[d] = 1'b1;
    tick();
    fetch[d] = 1'b0;
    tick();
    test_reset("reset_in_wait");
  endtask

  task automatic test_halt(input int d);
    int bad;
    fetch[d] = 1'b1;
    tick();
    fetch[d] = 1'b0;
    tick();
    halt[d] = 1'b1;
    tick();
    halt[d] = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (re[d] !== 1'b0 || ce[d] !== 1'b0) bad++;
      fetch[d] = 1'($urandom);
      jmp[d] = 1'($urandom);
      jaddr[d] = 16'($urandom);
      tick();
    end
    fetch[d] = 1'b0;
    jmp[d] = 1'b0;
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL halted_quiet d%0d: %0d cycles with re/ce high, want 0", d, bad);
    end
    test_reset("reset_after_halt");
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h4105;
    mem[1] = 16'h2902;
    mem[2] = 16'h0000;
    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b1; fetch[d] = 1'b0; halt[d] = 1'b0; jmp[d] = 1'b0; jaddr[d] = 16'h0000;
    end
    tick();
    test_reset("reset");
    test_basic();
    test_jump_wait(0, 0, 16'h0040, "jump_wait_l1");
    test_jump_wait(1, 0, 16'h0040, "jump_wait_l3_first");
    test_jump_wait(1, 2, 16'h0040, "jump_wait_l3_last");
    test_jump_hold(0, 16'hFFFF, 1'b0, "jump_hold_wrap");
    test_jump_hold(1, 16'h1234, 1'b1, "jump_with_fetch");
    test_random();
    test_en_drop(0);
    test_en_drop(1);
    test_halt(0);
    test_halt(1);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/prco_fetch.md
Name: prco_fetch

Overview:
Instruction fetch unit that drives the decoder's fetch/issue handshake.
- Holds the program counter and reads 16-bit instruction words from instruction memory, which has a fixed read latency.
- Presents each word to the decoder with a one-cycle issue strobe, then waits for the decoder's fetch request before fetching the next word.
- Handles jump redirects, including discarding an in-flight read, and latches halt.

Parameters:
PC_W, 16, program counter and memory address width.
RESET_PC, 0, PC value loaded on reset.
MEM_LAT, 1, instruction memory read latency in cycles; legal range 1..3.

Ports:
i_clk  in  1  clock; all state updates on the rising edge.
i_reset  in  1  reset, asynchronous, active-low.
i_en  in  1  fetch enable; low stalls new requests.
i_fetch  in  1  one-cycle fetch request from the decoder (its q_fetch).
i_halt  in  1  halt request from the decoder (its q_halt).
i_jmp_en  in  1  one-cycle PC redirect strobe.
i_jmp_addr  in  PC_W  redirect target.
q_mem_addr  out  PC_W  instruction memory read address.
q_mem_re  out  1  instruction memory read strobe, one cycle per request.
i_mem_data  in  16  instruction memory read data.
q_instr  out  16  instruction word to the decoder (its i_instr).
q_ce  out  1  one-cycle issue strobe to the decoder (its i_ce).
q_pc  out  PC_W  address of the word on q_instr.
q_busy  out  1  high while a memory read is outstanding.

Behaviour:
Reset (i_reset low, asynchronous):
- pc=RESET_PC; state=BOOT.
- q_ce=0, q_mem_re=0, q_mem_addr=0, q_instr=16'h0000, q_pc=0, q_busy=0.
- Reset asserted mid-read abandons the read; data returning after reset is ignored.

State machine (BOOT, REQ, WAIT, ISSUE, HOLD, HALTED):
- BOOT: go to REQ when i_en=1; otherwise stay.
- REQ (one cycle): q_mem_re=1, q_mem_addr=pc, q_busy=1, load latency counter; go to WAIT.
- WAIT: counts MEM_LAT cycles. On the final cycle:
  - sample i_mem_data into q_instr;
  - q_pc<=pc; pc<=pc+1, wrapping 2^PC_W-1 to 0;
  - q_busy<=0; go to ISSUE.
- ISSUE (one cycle): q_ce=1; go to HOLD.
- HOLD: q_ce=0 and q_instr held stable. On i_fetch=1:
  - i_en=1: go to REQ;
  - i_en=0: go to BOOT.
  - i_fetch in any other state is ignored.
- HALTED: terminal until reset. q_ce=0, q_mem_re=0; i_fetch and i_jmp_en are ignored.

Latency:
- i_fetch sampled high at edge N gives q_mem_re high in cycle N+1.
- i_mem_data is sampled MEM_LAT cycles after that.
- q_ce is high in cycle N+2+MEM_LAT.
- First issue after reset release with i_en=1: q_ce in cycle 2+MEM_LAT.

Jump (i_jmp_en=1, any state except HALTED):
- pc<=i_jmp_addr. This overrides the WAIT increment in the same cycle.
- In WAIT, the in-flight word is discarded: no q_ce, q_instr and q_pc are unchanged, go to REQ. An extra memory read is allowed.
- In HOLD or BOOT, the next REQ uses the new pc.
- Jump and i_fetch in the same HOLD cycle: the fetch is taken and targets i_jmp_addr.

Halt (i_halt=1, any state): go to HALTED next edge and cancel any pending q_ce. Halt has priority over jump and fetch.

i_en=0 never aborts an outstanding read. The word completes and issues; only the next REQ is withheld.

q_mem_re and q_ce are single-cycle pulses and are never high in the same cycle.

Test Plan:
1. MEM_LAT=1, memory[0..2]=16'h4105,16'h2902,16'h0000; release reset, i_en=1, pulse i_fetch 3 cycles after each q_ce -> q_ce in cycle 3 with q_instr=4105, q_pc=0; then 2902 with q_pc=1; then 0000 with q_pc=2; exactly one q_mem_re per issue.
2. MEM_LAT=3; i_fetch at edge N -> q_mem_re in N+1 and q_ce in N+5; q_busy high for cycles N+1..N+4.
3. During WAIT, assert i_jmp_en with i_jmp_addr=16'h0040 -> stale word never issued (no q_ce); next issue has q_pc=0040 and q_instr=memory[0x40]; following issue has q_pc=0041.
4. PC_W=16, RESET_PC=16'hFFFF -> first issue q_pc=FFFF; second issue q_pc=0000.
5. i_halt pulsed in WAIT -> no q_ce, no further q_mem_re for 50 cycles despite i_fetch and i_jmp_en pulses; asserting reset restarts from RESET_PC.
6. i_en dropped in WAIT -> word still issues; an i_fetch while i_en=0 produces no q_mem_re; raising i_en restarts fetching at pc+1. Reset asserted in WAIT -> all outputs return to reset values immediately (asynchronously).
